ftoi_pipe: RTL
==============

// Module: ftoi_pipe
// PURPOSE
//   Two-stage pipelined IEEE-754 single-precision float to signed 32-bit integer converter.
//   Inverse of the FPU's int-to-float unit; sits beside it in the FPU as the FTOI datapath.
//   Rounds to nearest with ties away from zero; saturates out-of-range values.
//   Valid/ready handshake on both sides, with full-pipeline stall on backpressure.
// PARAMETERS
//   none (fixed binary32 -> int32)
// PORTS
//   clk        in   1   clock; all state updates on posedge
//   rst        in   1   asynchronous, active-high reset
//   in_valid   in   1   x carries a valid operand
//   in_ready   out  1   unit accepts x this cycle
//   x          in   32  binary32 operand {s, e[7:0], m[22:0]}
//   out_valid  out  1   res carries a valid result
//   out_ready  in   1   downstream accepts res this cycle
//   res        out  32  signed two's-complement result
// BEHAVIOUR
//   Reset (async assert, sync-free deassert):
//     - s1_valid = 0, out_valid = 0, res = 0, all stage registers = 0.
//     - in_ready = 1 while in reset and after it.
//   Global enable and handshake:
//     - en = ~out_valid | out_ready; in_ready = en (combinational, no other input dependence).
//     - Input transfer when in_valid & in_ready; output transfer when out_valid & out_ready.
//     - en = 0 freezes both stages; res and out_valid are held stable while out_valid & ~out_ready.
//     - Bubbles are not collapsed while stalled.
//   Latency: result appears 2 cycles after accept when unstalled; throughput is 1/cycle.
//   Stage 1 register (on en):
//     - captures s1_valid <= in_valid, sign, m24 = {1, m}, and a class code:
//       ZERO  e < 126
//       HALF  e = 126, magnitude in [0.5, 1)
//       RSH   127 <= e <= 149, shift right by 150 - e
//       LSH   150 <= e <= 157, shift left by e - 150
//       SAT   e >= 158, including inf and NaN
//     - Shift amount stored 5 bits wide.
//   Stage 2 (on en, registered into res / out_valid <= s1_valid):
//     - ZERO: mag = 0.
//     - HALF: mag = 1 (m24[23] is the round bit, always 1).
//     - RSH: mag = (m24 >> sh) + round bit, where the round bit is m24[sh-1]. mag < 2^24, so no overflow.
//     - LSH: mag = m24 << sh, exact. mag < 2^31.
//     - res = sign ? -mag : mag. Sign is ignored when mag = 0, so there is no negative zero.
//     - SAT: res = sign ? 32'h8000_0000 : 32'h7FFF_FFFF.
//       * NaN saturates by its sign bit.
//       * Exactly -2^31 (0xCF000000) yields 0x80000000.
//     - Denormals have e = 0, are class ZERO, and give 0.
//   Simultaneous events:
//     - Accept and output transfer in the same cycle are legal; the pipeline shifts by one.
//     - A stage 1 entry with s1_valid = 0 still advances.
//   Reset mid-operation: in-flight operands are discarded and out_valid drops immediately (async).
//   No exceptions or flags are produced.
// TESTING
//   T1 rounding:
//     - x = 0x40200000 (2.5) -> res = 3.
//     - 0xC0200000 (-2.5) -> 0xFFFFFFFD.
//     - 0x3FC00000 (1.5) -> 2.
//     - 0x3F7FFFFF -> 1.
//   T2 small and zero:
//     - 0x3F000000 (0.5) -> 1.
//     - 0x3EFFFFFF -> 0.
//     - 0x80000000 -> 0.
//     - 0x00400000 (denormal) -> 0.
//   T3 range edges:
//     - 0x4EFFFFFF -> 0x7FFFFF80.
//     - 0x4F000000 -> 0x7FFFFFFF.
//     - 0xCF000000 -> 0x80000000.
//     - 0x7FC00000 -> 0x7FFFFFFF.
//     - 0xFF800000 -> 0x80000000.
//   T4 latency and backpressure:
//     - 4 back-to-back inputs with out_ready = 1 -> results at cycles +2..+5.
//     - Then hold out_ready = 0 for 5 cycles mid-burst -> in_ready = 0 and res held.
//     - No loss or reorder after release.
//   T5 reset mid-operation:
//     - Assert rst while 2 operands are in flight -> out_valid = 0 and res = 0 within the same cycle.
//     - After release, in_ready = 1 and no stale result appears.
//   T6 round trip:
//     - 10k random ints with |x| < 2^24, converted by the FPU int-to-float unit -> ftoi_pipe returns the original int.
//     - Random binary32 inputs are checked against a C reference using roundf plus saturation.

Source files
------------

// File: rtl/ftoi_pipe_if.sv
// Valid/ready operand and result bundle between the FTOI datapath and its surroundings.
// The FPU side is master and the converter is slave.
interface ftoi_pipe_if;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] x;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] res;

    modport master (
        output in_valid, x, out_ready,
        input  in_ready, out_valid, res
    );

    modport slave (
        input  in_valid, x, out_ready,
        output in_ready, out_valid, res
    );
endinterface

// File: rtl/ftoi_pipe.sv
// Two-stage binary32 -> int32 converter: round to nearest, ties away from zero, saturating.
// Stage 1 classifies the exponent, stage 2 shifts, rounds and applies the sign.
module ftoi_pipe (
    input  logic       clk,
    input  logic       rst,
    ftoi_pipe_if.slave bus
);

    typedef enum logic [2:0] {
        CLS_ZERO,
        CLS_HALF,
        CLS_RSH,
        CLS_LSH,
        CLS_SAT
    } cls_t;

    logic        en;
    logic [7:0]  e;
    cls_t        cls_d;
    logic [4:0]  sh_d;

    logic        s1_valid;
    logic        s1_sign;
    logic [23:0] s1_m24;
    cls_t        s1_cls;
    logic [4:0]  s1_sh;

    logic [24:0] rsh_w;
    logic [31:0] mag;
    logic [31:0] res_d;
    logic [31:0] res_q;
    logic        out_valid_q;

    // A single enable stalls the whole pipe, so bubbles stay where they are.
    assign en           = ~out_valid_q | bus.out_ready;
    assign bus.in_ready = en;
    assign bus.out_valid = out_valid_q;
    assign bus.res       = res_q;

    assign e = bus.x[30:23];

    // NOTE: every output gets a default first so no path leaves it unassigned and infers a latch.
    always_comb begin
        cls_d = CLS_ZERO;
        sh_d  = '0;
        if (e >= 8'd158) begin
            cls_d = CLS_SAT;
        end else if (e >= 8'd150) begin
            cls_d = CLS_LSH;
            sh_d  = 5'(e - 8'd150);
        end else if (e >= 8'd127) begin
            cls_d = CLS_RSH;
            sh_d  = 5'(8'd150 - e);
        end else if (e == 8'd126) begin
            cls_d = CLS_HALF;
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_sign  <= 1'b0;
            s1_m24   <= '0;
            s1_cls   <= CLS_ZERO;
            s1_sh    <= '0;
        end else if (en) begin
            s1_valid <= bus.in_valid;
            s1_sign  <= bus.x[31];
            s1_m24   <= {1'b1, bus.x[22:0]};
            s1_cls   <= cls_d;
            s1_sh    <= sh_d;
        end
    end

    // The appended zero lands the round bit m24[sh-1] in bit 0 after the shift.
    assign rsh_w = {s1_m24, 1'b0} >> s1_sh;

    always_comb begin
        mag   = '0;
        res_d = '0;
        case (s1_cls)
            CLS_HALF: mag = 32'd1;
            CLS_RSH:  mag = {8'd0, rsh_w[24:1]} + {31'd0, rsh_w[0]};
            CLS_LSH:  mag = {8'd0, s1_m24} << s1_sh;
            default:  mag = '0;
        endcase
        res_d = s1_sign ? -mag : mag;
        if (s1_cls == CLS_SAT) begin
            res_d = s1_sign ? 32'h8000_0000 : 32'h7FFF_FFFF;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            res_q       <= '0;
        end else if (en) begin
            out_valid_q <= s1_valid;
            res_q       <= res_d;
        end
    end

endmodule
